elm_output_layer: RTL and testbench

//  Consumer end of the hidden-layer handoff. Captures the 300-node ReLU'd hidden vector when update rises.

---
 rtl/elm_pkg.sv | 38 +++
 rtl/elm_mac_unit.sv | 53 +++++
 rtl/elm_output_layer.sv | 213 +++++++++++++++++++++
 tb/tb_elm_output_layer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/elm_pkg.sv
// Shared constants and state encoding for the ELM engine.
// The hidden-layer block and the output layer both import this package.
package elm_pkg;

   localparam int BIT_LENGTH   = 21;
   localparam int LAYER_1_SIZE = 300;
   localparam int NUM_CLASSES  = 10;
   localparam int W_WIDTH      = 16;
   localparam int ACC_WIDTH    = 48;
   localparam int ADDR_WIDTH   = 12;

   // Derived widths
   localparam int HIDDEN_WIDTH = BIT_LENGTH * LAYER_1_SIZE;
   localparam int PROD_WIDTH   = BIT_LENGTH + 1 + W_WIDTH;   // zero-extended node times signed weight
   localparam int K_WIDTH      = 9;                          // holds 1..LAYER_1_SIZE
   localparam int CLASS_WIDTH  = 4;                          // holds 0..NUM_CLASSES-1

   localparam logic [K_WIDTH-1:0]     FIRST_K    = K_WIDTH'(1);
   localparam logic [K_WIDTH-1:0]     SECOND_K   = K_WIDTH'(2);
   localparam logic [K_WIDTH-1:0]     LAST_K     = K_WIDTH'(LAYER_1_SIZE);
   localparam logic [CLASS_WIDTH-1:0] LAST_CLASS = CLASS_WIDTH'(NUM_CLASSES - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MAC   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } elm_state_t;

   // Weight ROM address for class cls and 1-based node index k.
   function automatic logic [ADDR_WIDTH-1:0] rom_addr(input logic [CLASS_WIDTH-1:0] cls,
                                                      input logic [K_WIDTH-1:0]     k);
      logic [ADDR_WIDTH-1:0] base;
      base = ADDR_WIDTH'(cls) * ADDR_WIDTH'(LAYER_1_SIZE);
      return base + ADDR_WIDTH'(k) - ADDR_WIDTH'(1);
   endfunction

endpackage

// File: rtl/elm_mac_unit.sv
// Registered multiply-accumulate: acc += {0,node} * weight (signed).
// clear restarts the sum with the current product. acc_next exposes the
// value the register will take at the coming edge so the caller can compare
// a finished score in the same cycle its last product is added.
module elm_mac_unit
   import elm_pkg::*;
(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clear,
   input  logic                  enable,
   input  logic [BIT_LENGTH-1:0] node,
   input  logic [W_WIDTH-1:0]    weight,
   output logic [ACC_WIDTH-1:0]  acc_next
);

   logic signed [PROD_WIDTH-1:0] node_ext_s;
   logic signed [PROD_WIDTH-1:0] weight_ext_s;
   logic signed [PROD_WIDTH-1:0] product_s;
   logic signed [ACC_WIDTH-1:0]  product_acc_s;
   logic signed [ACC_WIDTH-1:0]  acc_d;
   logic signed [ACC_WIDTH-1:0]  acc_q;

   // Form the exact product (fits PROD_WIDTH) and the next accumulator value.
   always_comb begin
      node_ext_s    = $signed({{(W_WIDTH + 1){1'b0}}, node});
      weight_ext_s  = $signed({{(PROD_WIDTH - W_WIDTH){weight[W_WIDTH-1]}}, weight});
      product_s     = node_ext_s * weight_ext_s;
      product_acc_s = $signed({{(ACC_WIDTH - PROD_WIDTH){product_s[PROD_WIDTH-1]}}, product_s});
      acc_d         = acc_q;
      if (enable) begin
         if (clear) begin
            acc_d = product_acc_s;
         end else begin
            acc_d = acc_q + product_acc_s;
         end
      end else begin
         acc_d = acc_q;
      end
   end

   // Accumulator register.
   always_ff @(posedge clock) begin
      if (reset) begin
         acc_q <= {ACC_WIDTH{1'b0}};
      end else begin
         acc_q <= acc_d;
      end
   end

   assign acc_next = acc_d;

endmodule

// File: rtl/elm_output_layer.sv
// ELM output layer: captures the hidden vector on a rising update, computes
// one dot product per class against the external weight ROM (1-cycle read
// latency), and reports the argmax class with a single-cycle valid pulse.
// The Hidden bus keeps the same bit order as the hidden-layer producer:
// node 1 occupies the top BIT_LENGTH bits, MSB first, node 300 the bottom.
module elm_output_layer
   import elm_pkg::*;
(
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    update,
   input  logic [HIDDEN_WIDTH-1:0] Hidden,
   output logic [ADDR_WIDTH-1:0]   weight_addr,
   input  logic [W_WIDTH-1:0]      weight_data,
   output logic                    busy,
   output logic                    class_valid,
   output logic [CLASS_WIDTH-1:0]  class_id,
   output logic [ACC_WIDTH-1:0]    class_score
);

   elm_state_t                state_q, state_d;
   logic                      update_q, update_d;
   logic [HIDDEN_WIDTH-1:0]   hidden_q, hidden_d;
   logic [CLASS_WIDTH-1:0]    class_q, class_d;
   logic [K_WIDTH-1:0]        k_q, k_d;
   logic [ADDR_WIDTH-1:0]     weight_addr_q, weight_addr_d;
   logic [BIT_LENGTH-1:0]     node_q, node_d;
   logic signed [ACC_WIDTH-1:0] best_score_q, best_score_d;
   logic [CLASS_WIDTH-1:0]    best_id_q, best_id_d;
   logic                      class_valid_q, class_valid_d;
   logic [CLASS_WIDTH-1:0]    class_id_q, class_id_d;
   logic [ACC_WIDTH-1:0]      class_score_q, class_score_d;
   logic                      busy_q, busy_d;

   logic                      trigger_s;
   logic [BIT_LENGTH-1:0]     node_sel_s;
   logic                      mac_clear_s;
   logic                      mac_en_s;
   logic [ACC_WIDTH-1:0]      acc_next_raw_s;
   logic signed [ACC_WIDTH-1:0] acc_next_s;

   // Accept a rising update only when fully idle (busy already dropped).
   always_comb begin
      trigger_s = (state_q == ST_IDLE) && update && !update_q && !busy_q;
   end

   // Select the captured node addressed by k_q; it is registered so it lines
   // up with the weight returned by the ROM one cycle later.
   always_comb begin
      node_sel_s = {BIT_LENGTH{1'b0}};
      for (int i = 0; i < LAYER_1_SIZE; i++) begin
         node_sel_s = node_sel_s |
                      (hidden_q[HIDDEN_WIDTH - (i + 1) * BIT_LENGTH +: BIT_LENGTH] &
                       {BIT_LENGTH{(k_q == K_WIDTH'(i + 1))}});
      end
   end

   // State register and all datapath flops.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         update_q      <= 1'b0;
         hidden_q      <= {HIDDEN_WIDTH{1'b0}};
         class_q       <= {CLASS_WIDTH{1'b0}};
         k_q           <= {K_WIDTH{1'b0}};
         weight_addr_q <= {ADDR_WIDTH{1'b0}};
         node_q        <= {BIT_LENGTH{1'b0}};
         best_score_q  <= {ACC_WIDTH{1'b0}};
         best_id_q     <= {CLASS_WIDTH{1'b0}};
         class_valid_q <= 1'b0;
         class_id_q    <= {CLASS_WIDTH{1'b0}};
         class_score_q <= {ACC_WIDTH{1'b0}};
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         update_q      <= update_d;
         hidden_q      <= hidden_d;
         class_q       <= class_d;
         k_q           <= k_d;
         weight_addr_q <= weight_addr_d;
         node_q        <= node_d;
         best_score_q  <= best_score_d;
         best_id_q     <= best_id_d;
         class_valid_q <= class_valid_d;
         class_id_q    <= class_id_d;
         class_score_q <= class_score_d;
         busy_q        <= busy_d;
      end
   end

   // Next-state logic: IDLE -> MAC/DRAIN per class -> DONE -> IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (trigger_s) begin
               state_d = ST_MAC;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_MAC: begin
            if (k_q == LAST_K) begin
               state_d = ST_DRAIN;
            end else begin
               state_d = ST_MAC;
            end
         end
         ST_DRAIN: begin
            if (class_q == LAST_CLASS) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_MAC;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output/datapath logic: capture, counters, MAC control, argmax, result.
   always_comb begin
      update_d      = update;
      hidden_d      = hidden_q;
      class_d       = class_q;
      k_d           = k_q;
      node_d        = node_sel_s;
      best_score_d  = best_score_q;
      best_id_d     = best_id_q;
      class_valid_d = 1'b0;
      class_id_d    = class_id_q;
      class_score_d = class_score_q;
      mac_clear_s   = 1'b0;
      mac_en_s      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (trigger_s) begin
               hidden_d = Hidden;
               class_d  = {CLASS_WIDTH{1'b0}};
               k_d      = FIRST_K;
            end else begin
               hidden_d = hidden_q;
            end
         end
         ST_MAC: begin
            // Weight for node k-1 arrives while node k is addressed.
            mac_en_s    = (k_q != FIRST_K);
            mac_clear_s = (k_q == SECOND_K);
            if (k_q == LAST_K) begin
               k_d = k_q;
            end else begin
               k_d = k_q + K_WIDTH'(1);
            end
         end
         ST_DRAIN: begin
            // Last product lands now; acc_next_s is the finished class score.
            mac_en_s = 1'b1;
            if ((class_q == {CLASS_WIDTH{1'b0}}) || (acc_next_s > best_score_q)) begin
               best_score_d = acc_next_s;
               best_id_d    = class_q;
            end else begin
               best_score_d = best_score_q;
            end
            if (class_q == LAST_CLASS) begin
               class_d = class_q;
            end else begin
               class_d = class_q + CLASS_WIDTH'(1);
               k_d     = FIRST_K;
            end
         end
         ST_DONE: begin
            class_valid_d = 1'b1;
            class_id_d    = best_id_q;
            class_score_d = best_score_q;
         end
         default: begin
            class_valid_d = 1'b0;
         end
      endcase
   end

   // Registered ROM address and busy flag, both derived from the next state.
   always_comb begin
      if (state_d == ST_MAC) begin
         weight_addr_d = rom_addr(class_d, k_d);
      end else begin
         weight_addr_d = {ADDR_WIDTH{1'b0}};
      end
      busy_d = (state_d != ST_IDLE) || class_valid_d;
   end

   elm_mac_unit u_mac (
      .clock    (clock),
      .reset    (reset),
      .clear    (mac_clear_s),
      .enable   (mac_en_s),
      .node     (node_q),
      .weight   (weight_data),
      .acc_next (acc_next_raw_s)
   );

   assign acc_next_s  = $signed(acc_next_raw_s);
   assign weight_addr = weight_addr_q;
   assign busy        = busy_q;
   assign class_valid = class_valid_q;
   assign class_id    = class_id_q;
   assign class_score = class_score_q;

endmodule

// File: tb/tb_elm_output_layer.sv
// Scoreboard bench for elm_output_layer: directed runs push their expected
// class/score/cycle into a queue; a negedge monitor pops on class_valid.
module tb_elm_output_layer;
   import elm_pkg::*;

   localparam int ROM_DEPTH = NUM_CLASSES * LAYER_1_SIZE;
   localparam int LATENCY   = 1 + NUM_CLASSES * (LAYER_1_SIZE + 1);

   typedef struct {
      int                   cyc;
      logic [3:0]           id;
      logic [ACC_WIDTH-1:0] score;
   } exp_t;

   logic                    clock = 1'b0;
   logic                    reset;
   logic                    update;
   logic [HIDDEN_WIDTH-1:0] hidden;
   logic [ADDR_WIDTH-1:0]   weight_addr;
   logic [W_WIDTH-1:0]      weight_data;
   logic                    busy;
   logic                    class_valid;
   logic [CLASS_WIDTH-1:0]  class_id;
   logic [ACC_WIDTH-1:0]    class_score;

   logic [W_WIDTH-1:0] rom [0:ROM_DEPTH-1];
   exp_t exp_q[$];
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   trig_cyc = 0;
   bit   addr_chk_en = 1'b0;
   int   addr_err = 0;
   int   addr_max = 0;
   bit   busy_fall_chk = 1'b0;

   elm_output_layer dut (
      .clock       (clock),
      .reset       (reset),
      .update      (update),
      .Hidden      (hidden),
      .weight_addr (weight_addr),
      .weight_data (weight_data),
      .busy        (busy),
      .class_valid (class_valid),
      .class_id    (class_id),
      .class_score (class_score)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   // ROM model: one-cycle read latency
   always @(posedge clock) begin
      if (weight_addr < ADDR_WIDTH'(ROM_DEPTH)) weight_data <= rom[weight_addr];
      else weight_data <= '0;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Monitor: scoreboard pop, busy timing, address sequence
   always @(negedge clock) begin
      int n;
      logic [ADDR_WIDTH-1:0] ea;
      exp_t e;
      if (busy_fall_chk) begin
         check("busy_fall", {63'd0, busy}, 64'd0);
         busy_fall_chk = 1'b0;
      end
      if (class_valid === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("unexpected_valid", {63'd0, class_valid}, 64'd0);
         end else begin
            e = exp_q.pop_front();
            check("class_id", {60'd0, class_id}, {60'd0, e.id});
            check("class_score", {16'd0, class_score}, {16'd0, e.score});
            check("latency_cycle", 64'(cyc), 64'(e.cyc));
            check("busy_at_valid", {63'd0, busy}, 64'd1);
            busy_fall_chk = 1'b1;
         end
      end
      if (addr_chk_en) begin
         n = cyc - trig_cyc;
         if (n >= 0 && n <= LATENCY) begin
            if (n <= LATENCY - 2 && (n % 301) != 300) ea = ADDR_WIDTH'((n / 301) * 300 + (n % 301));
            else ea = '0;
            if (weight_addr !== ea) addr_err++;
            if (int'(weight_addr) > addr_max) addr_max = int'(weight_addr);
         end
      end
   end

   task automatic clear_all();
      hidden = '0;
      for (int i = 0; i < ROM_DEPTH; i++) rom[i] = '0;
   endtask

   task automatic set_node(input int k, input logic [BIT_LENGTH-1:0] v);
      hidden[HIDDEN_WIDTH - k * BIT_LENGTH +: BIT_LENGTH] = v;
   endtask

   task automatic trigger(input logic [3:0] id, input logic [ACC_WIDTH-1:0] score, input int hold);
      exp_t e;
      @(negedge clock);
      update = 1'b1;
      trig_cyc = cyc + 1;
      e.cyc = trig_cyc + LATENCY;
      e.id = id;
      e.score = score;
      exp_q.push_back(e);
      addr_err = 0;
      addr_max = 0;
      addr_chk_en = 1'b1;
      repeat (hold) @(negedge clock);
      update = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int t = 0;
      while (exp_q.size() != 0 && t < LATENCY + 200) begin
         @(negedge clock);
         t++;
      end
      check({name, "_timeout"}, 64'(exp_q.size()), 64'd0);
      repeat (3) @(negedge clock);
      check({name, "_addr_seq_errs"}, 64'(addr_err), 64'd0);
      check({name, "_addr_max_ok"}, {63'd0, (addr_max <= ROM_DEPTH - 1)}, 64'd1);
      addr_chk_en = 1'b0;
      exp_q.delete();
   endtask

   task automatic setup_ramp();
      clear_all();
      set_node(1, 21'd1);
      for (int c = 0; c < NUM_CLASSES; c++) rom[c * LAYER_1_SIZE] = W_WIDTH'(c * 10);
   endtask

   initial begin
      #1500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      update = 1'b0;
      clear_all();
      repeat (3) @(negedge clock);
      reset = 1'b0;

      // Idle after reset
      for (int i = 0; i < 100; i++) begin
         @(negedge clock);
         check("idle_valid", {63'd0, class_valid}, 64'd0);
         check("idle_busy", {63'd0, busy}, 64'd0);
         check("idle_addr", {52'd0, weight_addr}, 64'd0);
         check("idle_id", {60'd0, class_id}, 64'd0);
      end

      // All-zero hidden, update held two cycles
      clear_all();
      trigger(4'd0, 48'd0, 2);
      wait_done("zero");

      // Ramp: class c weight on node 1 is c*10
      setup_ramp();
      trigger(4'd9, 48'd90, 1);
      wait_done("ramp");

      // Tie between classes 3 and 7 keeps the lower index
      clear_all();
      set_node(1, 21'd5);
      rom[3 * LAYER_1_SIZE] = 16'd100;
      rom[7 * LAYER_1_SIZE] = 16'd100;
      trigger(4'd3, 48'd500, 1);
      wait_done("tie");

      // All-negative weights: class 6 is least negative (-3*1 + -1*2 = -5)
      clear_all();
      set_node(1, 21'd1);
      set_node(2, 21'd2);
      for (int i = 0; i < ROM_DEPTH; i++) rom[i] = 16'hFFFF;
      for (int c = 0; c < NUM_CLASSES; c++) rom[c * LAYER_1_SIZE] = W_WIDTH'(-(20 + c));
      rom[6 * LAYER_1_SIZE] = 16'hFFFD;
      trigger(4'd6, -48'sd5, 1);
      wait_done("neg");

      // Max magnitude: every node 2^20-1, every weight -32768, all classes tie
      clear_all();
      for (int k = 1; k <= LAYER_1_SIZE; k++) set_node(k, 21'h0FFFFF);
      for (int i = 0; i < ROM_DEPTH; i++) rom[i] = 16'h8000;
      trigger(4'd0, -48'sd10307911680000, 1);
      wait_done("maxmag");

      // Node MSB set is an unsigned magnitude
      clear_all();
      set_node(1, 21'h1FFFFF);
      rom[2 * LAYER_1_SIZE] = 16'd1;
      trigger(4'd2, 48'd2097151, 1);
      wait_done("msb");

      // Re-pulse at cycle 1000 is ignored; new Hidden must not be captured
      setup_ramp();
      trigger(4'd9, 48'd90, 1);
      while (cyc < trig_cyc + 999) @(negedge clock);
      for (int k = 1; k <= LAYER_1_SIZE; k++) set_node(k, 21'h0FFFFF);
      update = 1'b1;
      @(negedge clock);
      update = 1'b0;
      wait_done("repulse");

      // Reset at cycle 1500 aborts the run without class_valid
      setup_ramp();
      @(negedge clock);
      update = 1'b1;
      trig_cyc = cyc + 1;
      @(negedge clock);
      update = 1'b0;
      while (cyc < trig_cyc + 1499) @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      check("rst_busy", {63'd0, busy}, 64'd0);
      check("rst_addr", {52'd0, weight_addr}, 64'd0);
      check("rst_id", {60'd0, class_id}, 64'd0);
      check("rst_score", {16'd0, class_score}, 64'd0);
      @(negedge clock);
      reset = 1'b0;
      repeat (LATENCY) @(negedge clock);
      check("abort_no_valid_busy", {63'd0, busy}, 64'd0);

      // A fresh edge after reset completes normally
      trigger(4'd9, 48'd90, 1);
      wait_done("after_reset");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
